inst_loader: RTL and testbench

Boot-time program loader that sits directly upstream of the instruction memory and the processor core. It accepts a framed byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words, writes them into instruction memory from address 0, and verifies a checksum. It then releases the core via `cpu_run`. While `cpu_run` is low the core's PC is held at 0 by the top level.

---
 rtl/inst_loader_pkg.sv | 14 +
 rtl/inst_loader_byte_assembler.sv | 41 ++++
 rtl/inst_loader.sv | 126 ++++++++++++
 tb/tb_inst_loader.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/inst_loader_pkg.sv
// Shared state encodings and frame field constants for the boot loader.
// Combinational constants only: no latency and no backpressure.
// Imported by inst_loader.
package inst_loader_pkg;
    localparam logic [2:0] ST_HDR_LO = 3'd0;
    localparam logic [2:0] ST_HDR_HI = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_CHECK  = 3'd3;
    localparam logic [2:0] ST_RUN    = 3'd4;
    localparam logic [2:0] ST_ERROR  = 3'd5;

    localparam int HDR_LEN = 2;
    localparam int CHK_LEN = 1;
endpackage

// File: rtl/inst_loader_byte_assembler.sv
// Packs four consecutive bytes into a little-endian 32-bit word.
// word_done_o/word_o are combinational on the 4th accepted byte (0 cycles).
// No backpressure: a byte is taken on every cycle that en_i is high.
module byte_assembler (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic [7:0]  byte_i,
    output logic        word_done_o,
    output logic [31:0] word_o
);
    logic [1:0]  cnt_q, cnt_d;
    logic [23:0] sr_q, sr_d;

    // The three earlier bytes sit in sr_q; the 4th completes the word directly.
    assign word_done_o = en_i && (cnt_q == 2'd3);
    assign word_o      = {byte_i, sr_q};

    always_comb begin
        cnt_d = cnt_q;
        sr_d  = sr_q;
        if (clr_i) begin
            cnt_d = 2'd0;
            sr_d  = 24'd0;
        end else if (en_i) begin
            cnt_d = cnt_q + 2'd1;
            sr_d  = {byte_i, sr_q[23:8]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 2'd0;
            sr_q  <= 24'd0;
        end else begin
            cnt_q <= cnt_d;
            sr_q  <= sr_d;
        end
    end
endmodule

// File: rtl/inst_loader.sv
// Boot loader: parses a framed byte stream, writes words to imem, verifies XOR checksum.
// mem_we one cycle after a word's 4th byte; cpu_run/error one cycle after the deciding byte.
// in_ready is a state decode: high while loading, low in RUN/ERROR until start.
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int DEPTH  = 512
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              start,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_run,
    output logic              error,
    output logic [ADDR_W:0]   loaded_words
);
    localparam logic [16:0] DEPTH_L = 17'(DEPTH);

    logic [2:0]        state_q, state_d;
    logic [7:0]        n_lo_q, n_lo_d;
    logic [15:0]       n_q, n_d;
    logic [ADDR_W:0]   wcnt_q, wcnt_d, wcnt_inc;
    logic [7:0]        acc_q, acc_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              xfer, asm_clr, asm_en, word_done;
    logic [31:0]       word;
    logic [15:0]       n_full;

    assign in_ready = (state_q == ST_HDR_LO) || (state_q == ST_HDR_HI) ||
                      (state_q == ST_DATA)   || (state_q == ST_CHECK);
    assign xfer     = in_valid && in_ready;
    assign n_full   = {in_data, n_lo_q};
    assign wcnt_inc = wcnt_q + 1'b1;
    assign asm_clr  = xfer && (state_q == ST_HDR_HI);
    assign asm_en   = xfer && (state_q == ST_DATA);

    byte_assembler u_asm (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_i       (asm_clr),
        .en_i        (asm_en),
        .byte_i      (in_data),
        .word_done_o (word_done),
        .word_o      (word)
    );

    always_comb begin
        state_d = state_q;
        n_lo_d  = n_lo_q;
        n_d     = n_q;
        wcnt_d  = wcnt_q;
        acc_d   = acc_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_HDR_LO: if (xfer) begin
                n_lo_d  = in_data;
                state_d = ST_HDR_HI;
            end
            ST_HDR_HI: if (xfer) begin
                n_d    = n_full;
                wcnt_d = '0;
                acc_d  = 8'd0;
                if ({1'b0, n_full} > DEPTH_L) state_d = ST_ERROR;
                else if (n_full == 16'd0)     state_d = ST_CHECK;
                else                          state_d = ST_DATA;
            end
            ST_DATA: if (xfer) begin
                acc_d = acc_q ^ in_data;
                if (word_done) begin
                    we_d    = 1'b1;
                    addr_d  = wcnt_q[ADDR_W-1:0];
                    wdata_d = word;
                    wcnt_d  = wcnt_inc;
                    if (16'(wcnt_inc) == n_q) state_d = ST_CHECK;
                end
            end
            ST_CHECK: if (xfer) begin
                state_d = (in_data == acc_q) ? ST_RUN : ST_ERROR;
            end
            ST_RUN, ST_ERROR: if (start) begin
                state_d = ST_HDR_LO;
                wcnt_d  = '0;
            end
            default: state_d = ST_HDR_LO;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_HDR_LO;
            n_lo_q  <= 8'd0;
            n_q     <= 16'd0;
            wcnt_q  <= '0;
            acc_q   <= 8'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            n_lo_q  <= n_lo_d;
            n_q     <= n_d;
            wcnt_q  <= wcnt_d;
            acc_q   <= acc_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign mem_we       = we_q;
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign cpu_run      = (state_q == ST_RUN);
    assign error        = (state_q == ST_ERROR);
    assign loaded_words = wcnt_q;
endmodule

// File: tb/tb_inst_loader.sv
// Scoreboarded random bench for inst_loader: frames built from word lists, writes checked by a monitor.
module tb_inst_loader;
    localparam int ADDR_W = 9;
    localparam int DEPTH  = 512;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [31:0]       d;
    } wr_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'd0;
    logic              start = 1'b0;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_run;
    logic              error;
    logic [ADDR_W:0]   loaded_words;

    wr_t         exp_q[$];
    logic [31:0] frame_q[$];
    wr_t         mon_e;
    int          errors = 0;
    int          checks = 0;

    inst_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .start        (start),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_run      (cpu_run),
        .error        (error),
        .loaded_words (loaded_words)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Write monitor: every strobe must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst_n && mem_we) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected no write", mem_addr, mem_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", 32'(mem_addr), 32'(mon_e.a));
                check("wr_data", mem_wdata, mon_e.d);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int t;
        while (gap && $urandom_range(0, 2) == 0) begin
            in_valid = 1'b0;
            start    = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        t = 0;
        while (!in_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (!in_ready) check("ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic run_frame(input bit bad, input bit gap);
        int          n;
        logic [7:0]  chk;
        logic [15:0] nn;
        logic [31:0] w;
        wr_t         e;
        n   = frame_q.size();
        nn  = 16'(n);
        chk = 8'd0;
        for (int i = 0; i < n; i++) begin
            w   = frame_q[i];
            e.a = ADDR_W'(i);
            e.d = w;
            exp_q.push_back(e);
            chk = chk ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
        end
        if (bad) chk = chk ^ 8'h11;
        send_byte(nn[7:0], gap);
        send_byte(nn[15:8], gap);
        for (int i = 0; i < n; i++) begin
            w = frame_q[i];
            for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap);
        end
        send_byte(chk, gap);
        check("cpu_run_after_chk", 32'(cpu_run), bad ? 32'd0 : 32'd1);
        check("error_after_chk", 32'(error), bad ? 32'd1 : 32'd0);
        check("in_ready_after_chk", 32'(in_ready), 32'd0);
        check("loaded_words", 32'(loaded_words), 32'(n));
        check("writes_pending", 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;
        check("cpu_run_holds", 32'(cpu_run), bad ? 32'd0 : 32'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("rearm_cpu_run", 32'(cpu_run), 32'd0);
        check("rearm_error", 32'(error), 32'd0);
        check("rearm_loaded", 32'(loaded_words), 32'd0);
        check("rearm_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        check({tag, "_cpu_run"}, 32'(cpu_run), 32'd0);
        check({tag, "_error"}, 32'(error), 32'd0);
        check({tag, "_loaded"}, 32'(loaded_words), 32'd0);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        #3;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Nominal two-word program
        frame_q = {32'h0000_0013, 32'h0010_0093};
        run_frame(1'b0, 1'b0);
        pulse_start();

        // Same frame, corrupted checksum
        run_frame(1'b1, 1'b0);
        pulse_start();

        // Oversize header: N = 513
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        check("oversize_error", 32'(error), 32'd1);
        check("oversize_ready", 32'(in_ready), 32'd0);
        check("oversize_cpu_run", 32'(cpu_run), 32'd0);
        pulse_start();

        // Empty program
        frame_q = {};
        run_frame(1'b0, 1'b0);
        pulse_start();

        // Stalled nominal load, then reload with a single word
        frame_q = {32'h0000_0013, 32'h0010_0093};
        run_frame(1'b0, 1'b1);
        pulse_start();
        frame_q = {$urandom()};
        run_frame(1'b0, 1'b1);
        pulse_start();

        // Reset in the cycle the first word write is presented
        foreach (frame_q[i]) frame_q[i] = 32'd0;
        send_byte(8'h02, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h13, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        check("pre_reset_we", 32'(mem_we), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        frame_q = {32'h0000_0013, 32'h0010_0093};
        run_frame(1'b0, 1'b0);
        pulse_start();

        // Full-capacity program, N == DEPTH
        frame_q = {};
        for (int i = 0; i < DEPTH; i++) frame_q.push_back($urandom());
        run_frame(1'b0, 1'b0);
        pulse_start();

        // Random frames
        for (int r = 0; r < 10; r++) begin
            frame_q = {};
            for (int i = 0; i < int'($urandom_range(0, 8)); i++) frame_q.push_back($urandom());
            run_frame($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)));
            pulse_start();
        end

        repeat (5) @(posedge clk);
        #1;
        check("final_pending", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
